// File: rtl/gin_network_if.sv
// GLB-side and PE-side signal bundle for the global input network.
// master = GLB/PE-array side that drives words and readies; slave = the network.
interface gin_network_if #(
  parameter int NUMS_PE_ROW = 6,
  parameter int NUMS_PE_COL = 8,
  parameter int XID_BITS    = 5,
  parameter int YID_BITS    = 4,
  parameter int DATA_BITS   = 32
);
  localparam int NPE = NUMS_PE_ROW * NUMS_PE_COL;

  logic                     GLB_valid;
  logic                     GLB_ready;
  logic [DATA_BITS-1:0]     GLB_data;
  logic [XID_BITS-1:0]      tag_X;
  logic [YID_BITS-1:0]      tag_Y;
  logic                     set_XID;
  logic [XID_BITS-1:0]      XID_scan_in;
  logic                     set_YID;
  logic [YID_BITS-1:0]      YID_scan_in;
  logic [NPE-1:0]           PE_valid;
  logic [NPE-1:0]           PE_ready;
  logic [DATA_BITS*NPE-1:0] PE_data;

  modport master (
    output GLB_valid, GLB_data, tag_X, tag_Y,
    output set_XID, XID_scan_in, set_YID, YID_scan_in,
    output PE_ready,
    input  GLB_ready, PE_valid, PE_data
  );

  modport slave (
    input  GLB_valid, GLB_data, tag_X, tag_Y,
    input  set_XID, XID_scan_in, set_YID, YID_scan_in,
    input  PE_ready,
    output GLB_ready, PE_valid, PE_data
  );
endinterface

// File: rtl/gin_network.sv
// Multicasts one buffered GLB word to every PE whose scan-loaded (YID, XID) matches its tag; 1-cycle latency.
// GLB_ready drops while a word waits on any targeted PE or while an ID chain is shifting.
module gin_network #(
  parameter int NUMS_PE_ROW = 6,
  parameter int NUMS_PE_COL = 8,
  parameter int XID_BITS    = 5,
  parameter int YID_BITS    = 4,
  parameter int DATA_BITS   = 32
) (
  input  logic         clk,
  input  logic         rst,
  gin_network_if.slave bus
);
  localparam int NPE = NUMS_PE_ROW * NUMS_PE_COL;

  logic                 r_buf_v;
  logic [DATA_BITS-1:0] r_buf_data;
  logic [XID_BITS-1:0]  r_buf_tx;
  logic [YID_BITS-1:0]  r_buf_ty;
  logic [YID_BITS-1:0]  r_yid [NUMS_PE_ROW];
  logic [XID_BITS-1:0]  r_xid [NPE];

  logic           w_cfg;
  logic           w_live;
  logic           w_done;
  logic           w_glb_ready;
  logic [NPE-1:0] w_target;

  for (genvar k = 0; k < NPE; k++) begin : g_tgt
    assign w_target[k] = (r_yid[k / NUMS_PE_COL] == r_buf_ty) && (r_xid[k] == r_buf_tx);
  end

  // Holding reset masks the buffer so no PE handshake can complete in that cycle.
  assign w_live      = r_buf_v & rst;
  assign w_cfg       = bus.set_XID | bus.set_YID;
  assign w_done      = w_live & ~w_cfg & (&(~w_target | bus.PE_ready));
  assign w_glb_ready = ~w_cfg & (~w_live | w_done);

  assign bus.GLB_ready = w_glb_ready;
  assign bus.PE_valid  = w_target & {NPE{w_live & ~w_cfg}};
  assign bus.PE_data   = {NPE{r_buf_data}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf_v    <= 1'b0;
      r_buf_data <= '0;
      r_buf_tx   <= '0;
      r_buf_ty   <= '0;
      for (int i = 0; i < NUMS_PE_ROW; i++) r_yid[i] <= '0;
      for (int i = 0; i < NPE; i++) r_xid[i] <= '0;
    end else begin
      if (bus.set_YID) begin
        r_yid[0] <= bus.YID_scan_in;
        for (int i = 1; i < NUMS_PE_ROW; i++) r_yid[i] <= r_yid[i-1];
      end
      if (bus.set_XID) begin
        r_xid[0] <= bus.XID_scan_in;
        for (int i = 1; i < NPE; i++) r_xid[i] <= r_xid[i-1];
      end
      if (bus.GLB_valid && w_glb_ready) begin
        r_buf_v    <= 1'b1;
        r_buf_data <= bus.GLB_data;
        r_buf_tx   <= bus.tag_X;
        r_buf_ty   <= bus.tag_Y;
      end else if (w_done) begin
        r_buf_v <= 1'b0;
      end
    end
  end
endmodule

// File: doc/gin_network.md
Name: gin_network

Overview:
- Global Input Network: the GLB-to-PE direction of the global network. It carries one GLB data word to every PE whose configured (YID, XID) matches the transaction tag, so one word can be multicast.
- Sits between the GLB read port and the PE array. It is the mirror of the output-side gather network and uses the same scan-chain ID configuration and valid/ready handshake.
- Contains a one-entry input buffer, per-row YID registers and per-PE XID registers, match logic, and an all-targets-ready multicast completion rule.

Parameters:
- NUMS_PE_ROW, 6, PE rows (Y dimension)
- NUMS_PE_COL, 8, PEs per row (X dimension)
- XID_BITS, 5, width of tag_X and each PE XID
- YID_BITS, 4, width of tag_Y and each row YID
- DATA_BITS, 32, width of a data word

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset
- GLB_valid  in  1  GLB offers a word
- GLB_ready  out  1  network accepts the word
- GLB_data  in  DATA_BITS  word from the GLB
- tag_X  in  XID_BITS  column tag, sampled with GLB_data
- tag_Y  in  YID_BITS  row tag, sampled with GLB_data
- set_XID  in  1  shift the XID scan chain by one position
- XID_scan_in  in  XID_BITS  XID chain input
- set_YID  in  1  shift the YID scan chain by one position
- YID_scan_in  in  YID_BITS  YID chain input
- PE_valid  out  NUMS_PE_ROW*NUMS_PE_COL  per-PE valid; index k = row*NUMS_PE_COL + col
- PE_ready  in  NUMS_PE_ROW*NUMS_PE_COL  per-PE ready
- PE_data  out  DATA_BITS*NUMS_PE_ROW*NUMS_PE_COL  per-PE data; slice k = bits [DATA_BITS*k +: DATA_BITS]

Behaviour:
- Reset (rst==0 at a clk edge):
  - buffer empty (buf_v=0), buf_data/buf_tx/buf_ty = 0
  - all YID and XID registers = 0
  - Resulting outputs: PE_valid=0, PE_data=0. GLB_ready follows the normal rule: it is 1 when no set_* is asserted, 0 otherwise.
  - A reset in mid-transfer drops the buffered word; no PE handshake completes in that cycle.
- YID chain (set_YID=1 at an edge):
  - YID[0] <= YID_scan_in; YID[i] <= old YID[i-1] for i>0.
  - NUMS_PE_ROW pulses fully load the chain. The last value shifted in lands in row 0.
- XID chain (set_XID=1 at an edge):
  - Row-major chain over k = 0..ROW*COL-1: XID[0] <= XID_scan_in; XID[k] <= old XID[k-1].
  - set_XID and set_YID may be asserted together; both chains shift.
- Target vector:
  - target[k] = (YID[row(k)]==buf_ty) && (XID[k]==buf_tx).
  - Computed combinationally from the current ID registers.
- Config stall:
  - While set_XID or set_YID is 1: GLB_ready=0 and PE_valid=0.
  - The buffered word is held and is re-evaluated against the new IDs afterwards.
- Outputs:
  - PE_valid[k] = buf_v && target[k] && !cfg, where cfg = set_XID|set_YID.
  - Every PE_data slice = buf_data (broadcast).
- Completion (combinational):
  - done = buf_v && !cfg && (for every k: !target[k] || PE_ready[k]).
  - All targeted PEs take the word in the same cycle. There is no partial delivery and no per-PE bookkeeping.
  - No-match case: if target==0, done=1 in the first non-stalled cycle and the word is silently dropped.
- Accept: GLB_ready = !cfg && (!buf_v || done).
- At each edge with rst==1:
  - If GLB_valid && GLB_ready: buf_v<=1, and {buf_data, buf_tx, buf_ty} <= {GLB_data, tag_X, tag_Y}.
  - Else if done: buf_v<=0.
- Latency and throughput:
  - A word accepted at edge t appears on PE_valid in cycle t+1.
  - Sustained rate is 1 word/cycle when targets are ready (accept and done in the same cycle).
- Backpressure:
  - GLB_ready=0 while buf_v && !done.
  - Buffer and tags stay stable until done.
- Multicast:
  - Several PEs sharing an (XID, YID) pair receive the same word simultaneously.
  - Rows whose YID mismatches see PE_valid=0 regardless of their XIDs.

Test Plan:
1. Reset then scan config:
   - Stimulus: rst=0 for 2 cycles; release; 6 set_YID pulses with values 5,4,3,2,1,0; 48 set_XID pulses with values 47-k mod 32.
   - Required: YID[r]=r; XID[k]=k mod 32; PE_valid=0 throughout.
2. Unicast:
   - Stimulus: tag_Y=2, tag_X=17 (k=17), GLB_data=0xDEADBEEF, PE_ready all 1.
   - Required: GLB accepted at edge t; in cycle t+1 only PE_valid[17]=1 with slice 17 = 0xDEADBEEF; PE_valid=0 at t+2.
3. Multicast with a stalled target:
   - Stimulus: all YID=0, XID=3 for PEs 3, 11, 19; word 0x1234 with tag_Y=0, tag_X=3; PE_ready[11]=0 for 3 cycles.
   - Required: PE_valid = bits {3, 11, 19} held 3 cycles with GLB_ready=0; completes in the cycle PE_ready[11] rises; GLB_ready=1 in that same cycle.
4. Back-to-back streaming:
   - Stimulus: 8 words 0..7 to distinct single PEs, all ready.
   - Required: one delivery per cycle; GLB_ready stays 1; word n is at its PE in cycle n+1.
5. No match:
   - Stimulus: tag_Y=15, which no row holds.
   - Required: PE_valid stays 0; word dropped one cycle after accept; GLB_ready stays 1.
6. Config stall and reset mid-transfer:
   - Stimulus: with a buffered word whose PE_ready=0, assert set_XID for 1 cycle.
   - Required during stall: PE_valid=0 and GLB_ready=0; the word is re-evaluated against the new IDs.
   - Stimulus: then assert rst=0.
   - Required: buffer cleared; PE_valid=0 on the next cycle.
